pqc_seq: RTL and testbench
==========================

PQC_SEQ -- requirements
Module: pqc_seq

Interface
REQ-001 Parameter TIMEOUT, default 4096, max engine-run cycles before abort (range 2..65535).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instr_valid  input  1  decode-stage instruction valid.
REQ-005 opcode  input  7  instruction opcode.
REQ-006 funct3  input  3  instruction funct3.
REQ-007 funct7  input  7  instruction funct7.
REQ-008 ntt_done  input  1  NTT engine completion pulse.
REQ-009 pwam_done  input  1  PWAM engine completion pulse.
REQ-010 err_clr  input  1  clears sticky error flag.
REQ-011 stall  output  1  holds CPU pipeline.
REQ-012 ntt_start  output  1  one-cycle NTT launch pulse.
REQ-013 ntt_mode  output  1  0 = forward (funct7 3), 1 = inverse (funct7 4).
REQ-014 pwam_start  output  1  one-cycle PWAM launch pulse.
REQ-015 pwam_mode  output  2  funct7 5 -> 0, 6 -> 1, 7 -> 2.
REQ-016 dmem_owner  output  2  0 CPU, 1 PQC load/store, 2 NTT, 3 PWAM.
REQ-017 abort  output  1  one-cycle engine abort pulse on timeout.
REQ-018 err  output  1  sticky timeout flag.
REQ-019 illegal  output  1  combinational flag: unsupported PQC funct7.

Function
REQ-020 PQC instruction = instr_valid & opcode 7'b0001011 & funct3 3'b011; decode SHALL be acted on only in IDLE.
REQ-021 States SHALL be IDLE, NTT_RUN, PWAM_RUN, DONE.
REQ-022 IDLE, funct7 3/4: stall=1 combinationally; next state NTT_RUN; ntt_start=1 in first NTT_RUN cycle only; ntt_mode registered at launch.
REQ-023 IDLE, funct7 5/6/7: same as REQ-022 using PWAM_RUN, pwam_start and pwam_mode.
REQ-024 IDLE, funct7 0/1: dmem_owner=1 combinationally; no stall; no state change.
REQ-025 IDLE, funct7 2: dmem_owner=0; no stall; no state change.
REQ-026 IDLE, funct7 8..127: illegal=1 that cycle; no stall; no state change; outputs otherwise idle.
REQ-027 NTT_RUN: stall=1, dmem_owner=2; ntt_done -> DONE; pwam_done ignored.
REQ-028 PWAM_RUN: stall=1, dmem_owner=3; pwam_done -> DONE; ntt_done ignored.
REQ-029 A 16-bit timeout counter SHALL clear on RUN entry and increment each RUN cycle.
REQ-030 In a RUN cycle where the counter equals TIMEOUT-1 and done is low, the block SHALL pulse abort, set err, and go to DONE.
REQ-031 Done and timeout in the same cycle: done wins; no abort; err unchanged.
REQ-032 A done pulse arriving in the same cycle as start SHALL be accepted.
REQ-033 DONE: stall=0, dmem_owner=0, decode ignored, next state IDLE (one cycle); the stalled instruction retires here.
REQ-034 err SHALL hold until err_clr=1; err_clr and a timeout in the same cycle leave err=1.
REQ-035 Latency: launch to release = run cycles + 2 (1 decode/IDLE cycle + DONE cycle).
REQ-036 Start pulses SHALL never both be high; at most one engine runs at a time.

Reset
REQ-037 rst_n low SHALL immediately force IDLE and set counter 0, ntt_mode 0, pwam_mode 0, err 0.
REQ-038 Registered outputs SHALL read 0 during reset (stall, starts, abort, dmem_owner).
REQ-039 Reset mid-run SHALL abandon the run without asserting abort; the first cycle after release is IDLE.

Verification
REQ-040 funct7=3 decode, ntt_done 10 cycles after start -> ntt_start 1 pulse, ntt_mode=0, stall high 12 cycles, dmem_owner=2 during run, 0 in DONE.
REQ-041 funct7=6, pwam_done never, TIMEOUT=8 -> pwam_mode=1, abort pulse on 8th run cycle, err=1 until err_clr, return to IDLE.
REQ-042 funct7=1 valid -> dmem_owner=1, stall=0, no start; funct7=9 -> illegal=1, no state change.
REQ-043 ntt_done coincident with timeout cycle, TIMEOUT=4 -> DONE, abort=0, err=0.
REQ-044 rst_n low on 3rd PWAM_RUN cycle -> all outputs 0 immediately; after release, new funct7=4 launches NTT with ntt_mode=1.
REQ-045 New PQC decode held during DONE -> ignored; relaunch only if still valid in IDLE.

Source files
------------

// File: rtl/pqc_seq.sv
`default_nettype none
// ============================================================================
// Module   : pqc_seq
// Purpose  : Decodes PQC custom instructions, launches the NTT/PWAM engines,
//            stalls the CPU while an engine runs and aborts on timeout.
// Revision : 1.0
// ============================================================================
module pqc_seq #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       ntt_done,
    input  logic       pwam_done,
    input  logic       err_clr,
    output logic       stall,
    output logic       ntt_start,
    output logic       ntt_mode,
    output logic       pwam_start,
    output logic [1:0] pwam_mode,
    output logic [1:0] dmem_owner,
    output logic       abort,
    output logic       err,
    output logic       illegal
);
    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_NTT   = 2'd1;
    localparam logic [1:0]  c_ST_PWAM  = 2'd2;
    localparam logic [1:0]  c_ST_DONE  = 2'd3;
    localparam logic [6:0]  c_OPCODE   = 7'b0001011;
    localparam logic [2:0]  c_FUNCT3   = 3'b011;
    localparam logic [15:0] c_CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ntt_mode_q, ntt_mode_d;
    logic [1:0]  pwam_mode_q, pwam_mode_d;
    logic        err_q, err_d;

    logic w_pqc, w_ntt_op, w_pwam_op, w_ls_op, w_bad_op;
    logic w_running, w_done_in, w_timeout;

    // Decode only counts in IDLE and is masked while reset is held.
    assign w_pqc     = rst_n & instr_valid & (opcode == c_OPCODE) &
                       (funct3 == c_FUNCT3) & (state_q == c_ST_IDLE);
    assign w_ntt_op  = w_pqc & ((funct7 == 7'd3) | (funct7 == 7'd4));
    assign w_pwam_op = w_pqc & (funct7 >= 7'd5) & (funct7 <= 7'd7);
    assign w_ls_op   = w_pqc & (funct7 <= 7'd1);
    assign w_bad_op  = w_pqc & (funct7 >= 7'd8);

    assign w_running = (state_q == c_ST_NTT) | (state_q == c_ST_PWAM);
    assign w_done_in = ((state_q == c_ST_NTT)  & ntt_done) |
                       ((state_q == c_ST_PWAM) & pwam_done);
    // A done arriving on the last allowed cycle suppresses the abort.
    assign w_timeout = w_running & (cnt_q == c_CNT_LAST) & ~w_done_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_ST_IDLE;
            cnt_q       <= '0;
            ntt_mode_q  <= 1'b0;
            pwam_mode_q <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ntt_mode_q  <= ntt_mode_d;
            pwam_mode_q <= pwam_mode_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ntt_mode_d  = ntt_mode_q;
        pwam_mode_d = pwam_mode_q;
        err_d       = err_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_ntt_op) begin
                    state_d    = c_ST_NTT;
                    cnt_d      = '0;
                    ntt_mode_d = (funct7 == 7'd4);
                end else if (w_pwam_op) begin
                    state_d     = c_ST_PWAM;
                    cnt_d       = '0;
                    pwam_mode_d = funct7[1:0] - 2'd1;
                end
            end
            c_ST_NTT, c_ST_PWAM: begin
                cnt_d = cnt_q + 16'd1;
                if (w_done_in || w_timeout) begin
                    state_d = c_ST_DONE;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (w_timeout) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        stall      = w_ntt_op | w_pwam_op | w_running;
        ntt_start  = (state_q == c_ST_NTT)  & (cnt_q == '0);
        pwam_start = (state_q == c_ST_PWAM) & (cnt_q == '0);
        ntt_mode   = ntt_mode_q;
        pwam_mode  = pwam_mode_q;
        abort      = w_timeout;
        err        = err_q;
        illegal    = w_bad_op;
        dmem_owner = 2'd0;
        case (state_q)
            c_ST_IDLE: dmem_owner = w_ls_op ? 2'd1 : 2'd0;
            c_ST_NTT:  dmem_owner = 2'd2;
            c_ST_PWAM: dmem_owner = 2'd3;
            default:   dmem_owner = 2'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pqc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pqc_seq
// Purpose  : Three pqc_seq instances (TIMEOUT 4, 8, 4096) share one stimulus
//            stream and are compared against a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_pqc_seq;
    logic       clk = 1'b0;
    logic       rst_n, instr_valid, ntt_done, pwam_done, err_clr;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [2:0] stall_w, nstart_w, nmode_w, pstart_w, abort_w, err_w, ill_w;
    logic [2:0][1:0] pmode_w, own_w;
    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pqc_seq #(.TIMEOUT((g == 0) ? 4 : (g == 1) ? 8 : 4096)) u_dut (
            .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
            .opcode(opcode), .funct3(funct3), .funct7(funct7),
            .ntt_done(ntt_done), .pwam_done(pwam_done), .err_clr(err_clr),
            .stall(stall_w[g]), .ntt_start(nstart_w[g]), .ntt_mode(nmode_w[g]),
            .pwam_start(pstart_w[g]), .pwam_mode(pmode_w[g]),
            .dmem_owner(own_w[g]), .abort(abort_w[g]), .err(err_w[g]),
            .illegal(ill_w[g])
        );
    end

    // Reference model: engine 0 idle, 1 NTT running, 2 PWAM running, 3 retire cycle.
    int         m_eng   [3] = '{0, 0, 0};
    int         m_run   [3] = '{0, 0, 0};
    logic       m_nmode [3] = '{1'b0, 1'b0, 1'b0};
    logic [1:0] m_pmode [3] = '{2'd0, 2'd0, 2'd0};
    logic       m_err   [3] = '{1'b0, 1'b0, 1'b0};

    function automatic int to_of(int k);
        return (k == 0) ? 4 : (k == 1) ? 8 : 4096;
    endfunction

    function automatic bit is_pqc();
        return rst_n && instr_valid && opcode == 7'h0B && funct3 == 3'd3;
    endfunction

    function automatic bit eng_done(int k);
        return (m_eng[k] == 1 && ntt_done) || (m_eng[k] == 2 && pwam_done);
    endfunction

    function automatic bit eng_abort(int k);
        return (m_eng[k] == 1 || m_eng[k] == 2) && !eng_done(k) && m_run[k] == to_of(k) - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_eng[k] <= 0; m_run[k] <= 0; m_nmode[k] <= 1'b0;
                m_pmode[k] <= 2'd0; m_err[k] <= 1'b0;
            end else begin
                case (m_eng[k])
                    0: begin
                        if (is_pqc() && (funct7 == 7'd3 || funct7 == 7'd4)) begin
                            m_eng[k] <= 1; m_run[k] <= 0; m_nmode[k] <= (funct7 == 7'd4);
                        end else if (is_pqc() && funct7 >= 7'd5 && funct7 <= 7'd7) begin
                            m_eng[k] <= 2; m_run[k] <= 0; m_pmode[k] <= 2'(funct7 - 7'd5);
                        end
                    end
                    1, 2: begin
                        if (eng_done(k) || eng_abort(k)) m_eng[k] <= 3;
                        else m_run[k] <= m_run[k] + 1;
                    end
                    default: m_eng[k] <= 0;
                endcase
                if (eng_abort(k)) m_err[k] <= 1'b1;
                else if (err_clr) m_err[k] <= 1'b0;
            end
        end
    end

    function automatic logic [10:0] exp_vec(int k);
        logic st, ns, ps, il;
        logic [1:0] own;
        st = 1'b0; ns = 1'b0; ps = 1'b0; il = 1'b0; own = 2'd0;
        if (m_eng[k] == 0) begin
            st = is_pqc() && funct7 >= 7'd3 && funct7 <= 7'd7;
            il = is_pqc() && funct7 >= 7'd8;
            if (is_pqc() && funct7 <= 7'd1) own = 2'd1;
        end else if (m_eng[k] != 3) begin
            st  = 1'b1;
            own = (m_eng[k] == 1) ? 2'd2 : 2'd3;
            ns  = m_eng[k] == 1 && m_run[k] == 0;
            ps  = m_eng[k] == 2 && m_run[k] == 0;
        end
        return {st, ns, m_nmode[k], ps, m_pmode[k], own, eng_abort(k), m_err[k], il};
    endfunction

    function automatic logic [10:0] obs_vec(int k);
        return {stall_w[k], nstart_w[k], nmode_w[k], pstart_w[k], pmode_w[k],
                own_w[k], abort_w[k], err_w[k], ill_w[k]};
    endfunction

    task automatic drive_idle();
        instr_valid = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        ntt_done = 1'b0; pwam_done = 1'b0; err_clr = 1'b0;
    endtask

    task automatic issue(input logic [6:0] f7);
        instr_valid = 1'b1; opcode = 7'h0B; funct3 = 3'd3; funct7 = f7;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) rst_n = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_vec(k) !== 11'd0) begin
                    n_miss++;
                    $display("FAIL reset_state dut%0d c%0d: got %b want 0", k, c, obs_vec(k));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ntt_launch();
        int stall_n = 0, start_n = 0, own2_n = 0;
        logic [2:0] done_view = 3'b111;
        for (int c = 0; c < 20; c++) begin
            drive_idle();
            if (c == 0) issue(7'd3);
            ntt_done = (c == 11);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_miss++;
                    $display("FAIL ntt_launch dut%0d c%0d: got %b want %b", k, c, obs_vec(k), exp_vec(k));
                end
            end
            if (stall_w[2] === 1'b1) stall_n++;
            if (nstart_w[2] === 1'b1 && nmode_w[2] === 1'b0) start_n++;
            if (own_w[2] === 2'd2) own2_n++;
            if (c == 12) done_view = {stall_w[2], own_w[2]};
            @(posedge clk); #1;
        end
        n_vec++;
        if (stall_n != 12 || start_n != 1 || own2_n != 11 || done_view !== 3'b000) begin
            n_miss++;
            $display("FAIL ntt_latency: stall=%0d start=%0d own2=%0d done=%b want 12 1 11 000",
                     stall_n, start_n, own2_n, done_view);
        end
    endtask

    task automatic test_pwam_timeout();
        int ab_n = 0, ab_c = -1;
        logic [1:0] pm = 2'd0;
        drive_idle(); err_clr = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        n_vec++;
        if (err_w !== 3'b000) begin
            n_miss++; $display("FAIL err_clear_pre: got %b want 000", err_w);
        end
        for (int c = 0; c < 16; c++) begin
            drive_idle();
            if (c == 0) issue(7'd6);
            err_clr   = (c == 4);
            pwam_done = (c == 13);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_miss++;
                    $display("FAIL pwam_timeout dut%0d c%0d: got %b want %b", k, c, obs_vec(k), exp_vec(k));
                end
            end
            if (abort_w[1] === 1'b1) begin ab_n++; ab_c = c; end
            if (c == 1) pm = pmode_w[1];
            @(posedge clk); #1;
        end
        n_vec++;
        if (ab_n != 1 || ab_c != 8 || pm !== 2'd1 || err_w !== 3'b011) begin
            n_miss++;
            $display("FAIL pwam_abort: n=%0d cyc=%0d mode=%0d err=%b want 1 8 1 011", ab_n, ab_c, pm, err_w);
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        n_vec++;
        if (err_w !== 3'b000) begin
            n_miss++; $display("FAIL err_clear_post: got %b want 000", err_w);
        end
    endtask

    typedef struct { logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic [1:0] own; logic ill; } ls_t;

    task automatic test_loadstore_illegal();
        ls_t tbl [8] = '{
            '{7'h0B, 3'd3, 7'd1,   2'd1, 1'b0}, '{7'h0B, 3'd3, 7'd0,  2'd1, 1'b0},
            '{7'h0B, 3'd3, 7'd2,   2'd0, 1'b0}, '{7'h0B, 3'd3, 7'd9,  2'd0, 1'b1},
            '{7'h0B, 3'd3, 7'd127, 2'd0, 1'b1}, '{7'h0B, 3'd3, 7'd8,  2'd0, 1'b1},
            '{7'h0B, 3'd2, 7'd3,   2'd0, 1'b0}, '{7'h33, 3'd3, 7'd5,  2'd0, 1'b0}};
        for (int i = 0; i < 16; i++) begin
            drive_idle();
            if (i % 2 == 0) begin
                instr_valid = 1'b1; opcode = tbl[i/2].op; funct3 = tbl[i/2].f3; funct7 = tbl[i/2].f7;
            end
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_miss++;
                    $display("FAIL ls_model dut%0d i%0d: got %b want %b", k, i, obs_vec(k), exp_vec(k));
                end
            end
            if (i % 2 == 0) begin
                n_vec++;
                if (own_w[0] !== tbl[i/2].own || ill_w[0] !== tbl[i/2].ill || stall_w !== 3'b000) begin
                    n_miss++;
                    $display("FAIL ls_decode f7=%0d: own=%0d ill=%b stall=%b want own=%0d ill=%b stall=000",
                             tbl[i/2].f7, own_w[0], ill_w[0], stall_w, tbl[i/2].own, tbl[i/2].ill);
                end
            end else begin
                n_vec++;
                if (stall_w !== 3'b000 || nstart_w !== 3'b000 || pstart_w !== 3'b000) begin
                    n_miss++;
                    $display("FAIL ls_no_state_change i%0d: stall=%b ns=%b ps=%b want 000", i, stall_w, nstart_w, pstart_w);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_done_timeout_tie();
        logic [2:0] ab_any = 3'b000;
        logic [2:0] st5 = 3'b111;
        for (int c = 0; c < 8; c++) begin
            drive_idle();
            if (c == 0) issue(7'd3);
            ntt_done = (c == 4);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_miss++;
                    $display("FAIL tie_model dut%0d c%0d: got %b want %b", k, c, obs_vec(k), exp_vec(k));
                end
            end
            ab_any |= abort_w;
            if (c == 5) st5 = stall_w;
            @(posedge clk); #1;
        end
        n_vec++;
        if (ab_any !== 3'b000 || err_w !== 3'b000 || st5 !== 3'b000) begin
            n_miss++;
            $display("FAIL done_beats_timeout: abort=%b err=%b stall_done=%b want 000 000 000", ab_any, err_w, st5);
        end
    endtask

    task automatic test_done_with_start();
        logic [2:0] ps1 = 3'b000, st2 = 3'b111;
        for (int c = 0; c < 4; c++) begin
            drive_idle();
            if (c == 0) issue(7'd5);
            pwam_done = (c == 1);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_miss++;
                    $display("FAIL start_done_model dut%0d c%0d: got %b want %b", k, c, obs_vec(k), exp_vec(k));
                end
            end
            if (c == 1) ps1 = pstart_w;
            if (c == 2) st2 = stall_w;
            @(posedge clk); #1;
        end
        n_vec++;
        if (ps1 !== 3'b111 || st2 !== 3'b000) begin
            n_miss++;
            $display("FAIL done_with_start: pstart=%b stall_next=%b want 111 000", ps1, st2);
        end
    endtask

    task automatic test_reset_midrun();
        logic [2:0] ab_any = 3'b000, ns1 = 3'b000, nm1 = 3'b000;
        for (int c = 0; c < 3; c++) begin
            drive_idle();
            if (c == 0) issue(7'd7);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_miss++;
                    $display("FAIL midrun_model dut%0d c%0d: got %b want %b", k, c, obs_vec(k), exp_vec(k));
                end
            end
            @(posedge clk); #1;
        end
        drive_idle();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({stall_w, nstart_w, nmode_w, pstart_w, abort_w, err_w, ill_w, pmode_w, own_w} !== '0) begin
            n_miss++;
            $display("FAIL reset_midrun: stall=%b pstart=%b pmode=%b own=%b abort=%b want all 0",
                     stall_w, pstart_w, pmode_w, own_w, abort_w);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive_idle();
            if (c == 0) issue(7'd4);
            ntt_done = (c == 3);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_miss++;
                    $display("FAIL relaunch_model dut%0d c%0d: got %b want %b", k, c, obs_vec(k), exp_vec(k));
                end
            end
            ab_any |= abort_w;
            if (c == 1) begin ns1 = nstart_w; nm1 = nmode_w; end
            @(posedge clk); #1;
        end
        n_vec++;
        if (ns1 !== 3'b111 || nm1 !== 3'b111 || ab_any !== 3'b000) begin
            n_miss++;
            $display("FAIL relaunch_inverse: nstart=%b nmode=%b abort=%b want 111 111 000", ns1, nm1, ab_any);
        end
    endtask

    task automatic test_done_hold();
        for (int v = 0; v < 2; v++) begin
            logic [2:0] st3 = 3'b111, st4 = 3'b000, ps5 = 3'b000, ps_any = 3'b000;
            for (int c = 0; c < 9; c++) begin
                drive_idle();
                if (c <= 2) issue(7'd3);
                if (c == 3 || (v == 1 && c == 4)) issue(7'd5);
                ntt_done  = (c == 2);
                pwam_done = (v == 1 && c == 6);
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    n_vec++;
                    if (obs_vec(k) !== exp_vec(k)) begin
                        n_miss++;
                        $display("FAIL hold_model v%0d dut%0d c%0d: got %b want %b", v, k, c, obs_vec(k), exp_vec(k));
                    end
                end
                ps_any |= pstart_w;
                if (c == 3) st3 = stall_w;
                if (c == 4) st4 = stall_w;
                if (c == 5) ps5 = pstart_w;
                @(posedge clk); #1;
            end
            n_vec++;
            if (st3 !== 3'b000 || (v == 0 && ps_any !== 3'b000) ||
                (v == 1 && (st4 !== 3'b111 || ps5 !== 3'b111))) begin
                n_miss++;
                $display("FAIL decode_in_done v%0d: stall_done=%b stall_idle=%b pstart=%b/%b",
                         v, st3, st4, ps5, ps_any);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            instr_valid = ($urandom_range(0, 99) < 40);
            opcode      = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h0B;
            funct3      = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd3;
            funct7      = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 8));
            ntt_done    = ($urandom_range(0, 99) < 12);
            pwam_done   = ($urandom_range(0, 99) < 12);
            err_clr     = ($urandom_range(0, 99) < 6);
            rst_n       = ($urandom_range(0, 199) != 0);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_miss++;
                    $display("FAIL random dut%0d c%0d: got %b want %b", k, c, obs_vec(k), exp_vec(k));
                end
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_ntt_launch();
        test_pwam_timeout();
        test_loadstore_illegal();
        test_done_timeout_tie();
        test_done_with_start();
        test_reset_midrun();
        test_done_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
